// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: stage register fields in, forwarding/stall/flush controls out.
// master = pipeline side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;
  logic [1:0]  res_src_e;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic        pc_src_e;
  logic        mdu_start_e;
  logic [1:0]  fwd_a_e;
  logic [1:0]  fwd_b_e;
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        flush_d;
  logic        flush_e;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, rd_w, reg_write_w,
           pc_src_e, mdu_start_e,
    input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
           mdu_busy, mdu_done, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src_e, rd_w, reg_write_w,
           pc_src_e, mdu_start_e,
    output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, flush_d, flush_e,
           mdu_busy, mdu_done, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 4-stage core: W->E forwarding, load-use stall, branch flush, MDU freeze.
// Define HAZARD_PERF_EN to build the stall_cycles / flush_events performance counters.
module hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MDU_LATENCY - 2);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic fwdA;
  logic fwdB;
  logic lwStall;
  logic mduStall;
  logic stallFront;

  // BUSY counts down the remaining stall cycles after the cycle that saw the start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz.mdu_start_e) begin
            state_q <= BUSY;
            cnt_q   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fwdA = hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs1_e);
  assign fwdB = hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == hz.rs2_e);

  assign lwStall  = (hz.res_src_e == 2'b01) && (hz.rd_e != 5'd0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
  assign mduStall = rst_n && (((state_q == IDLE) && hz.mdu_start_e) || (state_q == BUSY));

  // A taken branch wins over a load-use stall, but an MDU freeze holds regardless.
  assign stallFront = mduStall || (rst_n && lwStall && !hz.pc_src_e);

  assign hz.fwd_a_e  = (rst_n && fwdA) ? 2'b01 : 2'b00;
  assign hz.fwd_b_e  = (rst_n && fwdB) ? 2'b01 : 2'b00;
  assign hz.stall_f  = stallFront;
  assign hz.stall_d  = stallFront;
  assign hz.stall_e  = mduStall;
  assign hz.flush_d  = !rst_n || hz.pc_src_e;
  assign hz.flush_e  = !rst_n || hz.pc_src_e || (lwStall && !mduStall);
  assign hz.mdu_busy = mduStall;
  assign hz.mdu_done = rst_n && (state_q == DONE);

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCycles_q;
  logic [31:0] stallCycles_d;
  logic [31:0] flushEvents_q;
  logic [31:0] flushEvents_d;

  always_comb begin
    stallCycles_d = stallCycles_q + (stallFront   ? 32'd1 : 32'd0);
    flushEvents_d = flushEvents_q + (hz.pc_src_e ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCycles_q <= '0;
      flushEvents_q <= '0;
    end else begin
      stallCycles_q <= stallCycles_d;
      flushEvents_q <= flushEvents_d;
    end
  end

  assign hz.stall_cycles = stallCycles_q;
  assign hz.flush_events = flushEvents_q;
`else
  assign hz.stall_cycles = 32'd0;
  assign hz.flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard cases plus random traffic against a cycle-level model.
// Expected counters follow HAZARD_PERF_EN the same way the design does.
module tb_hazard_ctrl;

  localparam int LAT = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D;
    logic [4:0] rs2D;
    logic [4:0] rs1E;
    logic [4:0] rs2E;
    logic [4:0] rdE;
    logic [1:0] resSrc;
    logic [4:0] rdW;
    logic       regWriteW;
    logic       pcSrc;
    logic       mduStart;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushD;
    logic        flushE;
    logic        busy;
    logic        done;
    logic [31:0] stallCycles;
    logic [31:0] flushEvents;
  } exp_t;

  logic clk;
  logic rst_n;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          opCycle = 0;
  logic [31:0] modelStalls = 32'd0;
  logic [31:0] modelFlushes = 32'd0;
  stim_t       st;

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  // Drive one cycle of inputs and queue the response the model predicts for it.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int   pos;
    logic lw;
    logic mduStall;
    @(posedge clk);
    #1;
    rst_n           = s.rst;
    hif.rs1_d       = s.rs1D;
    hif.rs2_d       = s.rs2D;
    hif.rs1_e       = s.rs1E;
    hif.rs2_e       = s.rs2E;
    hif.rd_e        = s.rdE;
    hif.res_src_e   = s.resSrc;
    hif.rd_w        = s.rdW;
    hif.reg_write_w = s.regWriteW;
    hif.pc_src_e    = s.pcSrc;
    hif.mdu_start_e = s.mduStart;

    if (!s.rst)           pos = 0;
    else if (opCycle > 0) pos = opCycle;
    else                  pos = s.mduStart ? 1 : 0;
    mduStall = (pos >= 1) && (pos <= LAT);
    lw = (s.resSrc == 2'b01) && (s.rdE != 0) && (s.rdE == s.rs1D || s.rdE == s.rs2D);

    e = '0;
    if (!s.rst) begin
      e.flushD = 1'b1;
      e.flushE = 1'b1;
    end else begin
      e.fwdA   = (s.regWriteW && s.rdW != 0 && s.rdW == s.rs1E) ? 2'b01 : 2'b00;
      e.fwdB   = (s.regWriteW && s.rdW != 0 && s.rdW == s.rs2E) ? 2'b01 : 2'b00;
      e.stallE = mduStall;
      e.stallF = mduStall || (lw && !s.pcSrc);
      e.stallD = e.stallF;
      e.flushD = s.pcSrc;
      e.flushE = s.pcSrc || (lw && !mduStall);
      e.busy   = mduStall;
      e.done   = (pos == LAT + 1);
    end
`ifdef HAZARD_PERF_EN
    e.stallCycles = modelStalls;
    e.flushEvents = modelFlushes;
`endif
    expQ.push_back(e);

    if (!s.rst) begin
      opCycle      = 0;
      modelStalls  = 32'd0;
      modelFlushes = 32'd0;
    end else begin
      opCycle      = (pos == 0 || pos == LAT + 1) ? 0 : pos + 1;
      modelStalls  = modelStalls + (e.stallF ? 32'd1 : 32'd0);
      modelFlushes = modelFlushes + (s.pcSrc ? 32'd1 : 32'd0);
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("fwd_a_e",      32'(hif.fwd_a_e),  32'(e.fwdA));
    cmp("fwd_b_e",      32'(hif.fwd_b_e),  32'(e.fwdB));
    cmp("stall_f",      32'(hif.stall_f),  32'(e.stallF));
    cmp("stall_d",      32'(hif.stall_d),  32'(e.stallD));
    cmp("stall_e",      32'(hif.stall_e),  32'(e.stallE));
    cmp("flush_d",      32'(hif.flush_d),  32'(e.flushD));
    cmp("flush_e",      32'(hif.flush_e),  32'(e.flushE));
    cmp("mdu_busy",     32'(hif.mdu_busy), 32'(e.busy));
    cmp("mdu_done",     32'(hif.mdu_done), 32'(e.done));
    cmp("stall_cycles", hif.stall_cycles,  e.stallCycles);
    cmp("flush_events", hif.flush_events,  e.flushEvents);
  endtask

  // Monitor: one queued expectation per driven cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    st = idleStim();
    st.rst = 1'b0;
    rst_n           = 1'b0;
    hif.rs1_d       = '0;
    hif.rs2_d       = '0;
    hif.rs1_e       = '0;
    hif.rs2_e       = '0;
    hif.rd_e        = '0;
    hif.res_src_e   = '0;
    hif.rd_w        = '0;
    hif.reg_write_w = 1'b0;
    hif.pc_src_e    = 1'b0;
    hif.mdu_start_e = 1'b0;

    applyStimulus(st);
    applyStimulus(st);
    applyStimulus(idleStim());

    st = idleStim();
    st.rdW = 5'd5; st.regWriteW = 1'b1; st.rs1E = 5'd5; st.rs2E = 5'd5;
    applyStimulus(st);
    st.rdW = 5'd0; st.rs1E = 5'd0;
    applyStimulus(st);

    st = idleStim();
    st.resSrc = 2'b01; st.rdE = 5'd7; st.rs2D = 5'd7;
    applyStimulus(st);
    st.rdE = 5'd0; st.rs2D = 5'd0;
    applyStimulus(st);
    st.rdE = 5'd7; st.rs2D = 5'd7; st.pcSrc = 1'b1;
    applyStimulus(st);

    st = idleStim();
    st.mduStart = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(st);
    st.mduStart = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(st);

    st = idleStim();
    st.mduStart = 1'b1;
    applyStimulus(st);
    applyStimulus(st);
    st.rst = 1'b0;
    applyStimulus(st);
    st = idleStim();
    for (int i = 0; i < 3; i++) applyStimulus(st);

    st = idleStim();
    st.resSrc = 2'b01; st.rdE = 5'd3; st.rs1D = 5'd3;
    for (int i = 0; i < 3; i++) applyStimulus(st);
    st = idleStim();
    st.pcSrc = 1'b1;
    applyStimulus(st);
    applyStimulus(st);
    st.pcSrc = 1'b0;
    applyStimulus(st);

`ifdef HAZARD_PERF_EN
    for (int i = 0; i < LAT + 3; i++) applyStimulus(idleStim());
    @(posedge clk);
    #1;
    force dut.stallCycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.stallCycles_q;
    modelStalls = 32'hFFFF_FFFF;
    st = idleStim();
    st.resSrc = 2'b01; st.rdE = 5'd9; st.rs2D = 5'd9;
    applyStimulus(st);
    applyStimulus(idleStim());
`endif

    for (int i = 0; i < 500; i++) begin
      st.rst       = ($urandom_range(0, 39) != 0);
      st.rs1D      = 5'($urandom_range(0, 3));
      st.rs2D      = 5'($urandom_range(0, 3));
      st.rs1E      = 5'($urandom_range(0, 3));
      st.rs2E      = 5'($urandom_range(0, 3));
      st.rdE       = 5'($urandom_range(0, 3));
      st.resSrc    = 2'($urandom_range(0, 3));
      st.rdW       = 5'($urandom_range(0, 3));
      st.regWriteW = 1'($urandom_range(0, 1));
      st.pcSrc     = ($urandom_range(0, 7) == 0);
      st.mduStart  = ($urandom_range(0, 5) == 0);
      applyStimulus(st);
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
